core_bus_arb: RTL and testbench

Two-master arbiter sharing the single core memory bus between the IFU fetch path and the LSU data path. It grants one request per bus handshake and records the owner of every accepted request in an in-order tracker. Each bus response is routed back to the master that issued it. It sits between core_ifu_top/LSU and the bus master controller.

---
 rtl/core_bus_arb.sv | 196 +++++++++++++++++++
 tb/tb_core_bus_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arb.sv
// core_bus_arb: two-master (IFU / LSU) arbiter for the shared core memory bus.
// Grants one request per bus handshake. The owner of each accepted request is
// queued in an in-order tracker, and each bus response is routed back to that owner.
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   ifu_req_*                      IFU read request (valid/ready/addr)
//   ifu_rsp_valid/data             IFU response (no backpressure)
//   lsu_req_*                      LSU request (valid/ready/addr/wen/wdata/wstrb)
//   lsu_rsp_valid/data             LSU response (read data or write ack)
//   bus_req_*                      request to the bus master controller
//   bus_rsp_valid/data             in-order bus responses
//   arb_err_orphan                 sticky flag: a response arrived with no outstanding request
//
// Request and response paths are combinational by design (zero-latency pass-through).
module core_bus_arb #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rsp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [31:0] lsu_req_wdata,
    input  logic [3:0]  lsu_req_wstrb,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rsp_data,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic        bus_req_wen,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data,
    output logic        arb_err_orphan
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned STRK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [0:0]        state, state_nxt;
    logic              hold_owner;
    logic              trk_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [STRK_W-1:0] streak;
    logic              orphan;

    logic sel_owner;
    logic sel_valid;
    logic full;
    logic empty;
    logic starving;
    logic req_valid;
    logic hs;
    logic pop;
    logic head_owner;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign starving   = (streak == STRK_W'(STARVE_LIMIT)) && ifu_req_valid;
    assign head_owner = trk_mem[rd_ptr];

    // Owner selection and next state.
    always_comb begin
        sel_owner = OWN_IFU;
        sel_valid = 1'b0;
        state_nxt = state;
        if (state == ST_HOLD) begin
            // Locked owner: a newly arriving higher-priority master is ignored.
            sel_owner = hold_owner;
            sel_valid = hold_owner ? lsu_req_valid : ifu_req_valid;
        end else if (lsu_req_valid && !starving) begin
            sel_owner = OWN_LSU;
            sel_valid = 1'b1;
        end else if (ifu_req_valid) begin
            sel_owner = OWN_IFU;
            sel_valid = 1'b1;
        end
        req_valid = rstn && sel_valid && !full;
        hs        = req_valid && bus_req_ready;
        if (state == ST_ARB) begin
            if (req_valid && !bus_req_ready) begin
                state_nxt = ST_HOLD;
            end
        end else if (hs) begin
            state_nxt = ST_ARB;
        end
    end

    // Bus request mux; IFU requests are always reads with zero payload.
    always_comb begin
        bus_req_valid = req_valid;
        ifu_req_ready = hs && (sel_owner == OWN_IFU);
        lsu_req_ready = hs && (sel_owner == OWN_LSU);
        if (sel_owner == OWN_LSU) begin
            bus_req_addr  = lsu_req_addr;
            bus_req_wen   = lsu_req_wen;
            bus_req_wdata = lsu_req_wdata;
            bus_req_wstrb = lsu_req_wstrb;
        end else begin
            bus_req_addr  = ifu_req_addr;
            bus_req_wen   = 1'b0;
            bus_req_wdata = 32'h0;
            bus_req_wstrb = 4'h0;
        end
    end

    // Response routing by tracker head.
    always_comb begin
        pop           = rstn && bus_rsp_valid && !empty;
        ifu_rsp_valid = pop && (head_owner == OWN_IFU);
        lsu_rsp_valid = pop && (head_owner == OWN_LSU);
        ifu_rsp_data  = bus_rsp_data;
        lsu_rsp_data  = bus_rsp_data;
    end

    assign arb_err_orphan = orphan;

    // State register and owner latch for HOLD.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_ARB;
            hold_owner <= OWN_IFU;
        end else begin
            state <= state_nxt;
            if (state == ST_ARB && req_valid && !bus_req_ready) begin
                hold_owner <= sel_owner;
            end
        end
    end

    // Tracker storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (hs) begin
            trk_mem[wr_ptr] <= sel_owner;
        end
    end

    // Tracker pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (hs) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (hs && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!hs && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // LSU grant streak while IFU waits; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            streak <= '0;
        end else if (!ifu_req_valid || (hs && sel_owner == OWN_IFU)) begin
            streak <= '0;
        end else if (hs && sel_owner == OWN_LSU && streak != STRK_W'(STARVE_LIMIT)) begin
            streak <= streak + STRK_W'(1);
        end
    end

    // Sticky orphan-response flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            orphan <= 1'b0;
        end else if (bus_rsp_valid && empty) begin
            orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_core_bus_arb.sv
// Scoreboard bench for core_bus_arb: expected bus requests are queued as the
// stimulus is planned, and the monitor pops them on each handshake; expected
// response owners follow the issue order of those expected requests.
module tb_core_bus_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_wen;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_data;
    logic        arb_err_orphan;

    always #5 clk = ~clk;

    core_bus_arb #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rstn(rstn),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
        .bus_req_wen(bus_req_wen), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
        .arb_err_orphan(arb_err_orphan)
    );

    typedef struct {
        logic        lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    req_t exp_q[$];
    logic own_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifu_req_valid = 1'b0; ifu_req_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_req_addr = 32'h0;
        lsu_req_wen = 1'b0; lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'h0;
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0; bus_rsp_data = 32'h0;
    endtask

    task automatic push_exp(input logic lsu, input logic [31:0] addr, input logic wen,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        req_t r;
        r.lsu = lsu; r.addr = addr; r.wen = wen; r.wdata = wdata; r.wstrb = wstrb;
        exp_q.push_back(r);
    endtask

    // Scoreboard monitor: request handshakes and response routing.
    always @(negedge clk) begin : mon
        req_t e;
        logic o;
        if (rstn) begin
            if (bus_req_valid && bus_req_ready) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_grant: got addr=%h exp no grant", bus_req_addr);
                end else begin
                    e = exp_q.pop_front();
                    own_q.push_back(e.lsu);
                    if ({lsu_req_ready, ifu_req_ready} !== {e.lsu, ~e.lsu} || bus_req_addr !== e.addr ||
                        bus_req_wen !== e.wen || bus_req_wdata !== e.wdata || bus_req_wstrb !== e.wstrb) begin
                        mismatched++;
                        $display("FAIL grant: got lr=%b ir=%b a=%h w=%b d=%h s=%h exp lsu=%b a=%h w=%b d=%h s=%h",
                                 lsu_req_ready, ifu_req_ready, bus_req_addr, bus_req_wen, bus_req_wdata,
                                 bus_req_wstrb, e.lsu, e.addr, e.wen, e.wdata, e.wstrb);
                    end
                end
            end
            if (bus_rsp_valid) begin
                compared++;
                if (own_q.size() == 0) begin
                    if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
                        mismatched++;
                        $display("FAIL orphan_route: got i=%b l=%b exp 0 0", ifu_rsp_valid, lsu_rsp_valid);
                    end
                end else begin
                    o = own_q.pop_front();
                    if (ifu_rsp_valid !== ~o || lsu_rsp_valid !== o ||
                        (o ? lsu_rsp_data : ifu_rsp_data) !== bus_rsp_data) begin
                        mismatched++;
                        $display("FAIL rsp_route: got i=%b l=%b id=%h ld=%h exp i=%b l=%b d=%h",
                                 ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data, lsu_rsp_data, ~o, o, bus_rsp_data);
                    end
                end
            end
        end
    end

    // Returns one response per outstanding request, data base, base+1, ...
    task automatic test_drain(input logic [31:0] base);
        int n;
        n = own_q.size();
        for (int i = 0; i < n; i++) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_data  = base + 32'(i);
            tick();
        end
        bus_rsp_valid = 1'b0;
        compared++;
        if (own_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_empty: got %0d left exp 0", own_q.size());
        end
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; bus_rsp_valid = 1'b1;
        tick();
        compared++;
        if ({bus_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b exp 00000",
                     {bus_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid});
        end
        tick();
        compared++;
        if (arb_err_orphan !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_orphan: got %b exp 0", arb_err_orphan);
        end
        idle();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_ifu_only();
        for (int k = 0; k < 3; k++) push_exp(1'b0, 32'(4 * k), 1'b0, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            ifu_req_valid = 1'b1;
            ifu_req_addr  = 32'(4 * k);
            #1;
            compared++;
            if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL ifu_only_ready: got i=%b l=%b exp 1 0", ifu_req_ready, lsu_req_ready);
            end
            tick();
        end
        idle();
        test_drain(32'hA);
    endtask

    task automatic test_starve();
        logic pat [8];
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++)
            push_exp(pat[k], pat[k] ? 32'h2000 : 32'h1000, 1'b0, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            ifu_req_valid = 1'b1; ifu_req_addr = 32'h1000;
            lsu_req_valid = 1'b1; lsu_req_addr = 32'h2000;
            bus_rsp_valid = (k > 0);
            bus_rsp_data  = 32'h100 + 32'(k);
            #1;
            compared++;
            if (lsu_req_ready !== pat[k] || ifu_req_ready !== ~pat[k]) begin
                mismatched++;
                $display("FAIL starve_pattern[%0d]: got l=%b i=%b exp l=%b", k, lsu_req_ready,
                         ifu_req_ready, pat[k]);
            end
            tick();
        end
        idle();
        test_drain(32'h200);
    endtask

    task automatic test_hold();
        push_exp(1'b0, 32'h3000, 1'b0, 32'h0, 4'h0);
        push_exp(1'b1, 32'h4000, 1'b0, 32'h0, 4'h0);
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h3000;
        for (int k = 0; k < 3; k++) begin
            bus_req_ready = (k == 2);
            if (k >= 1) begin
                lsu_req_valid = 1'b1; lsu_req_addr = 32'h4000;
            end
            #1;
            compared++;
            if (bus_req_valid !== 1'b1 || bus_req_addr !== 32'h3000 ||
                ifu_req_ready !== (k == 2) || lsu_req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL hold[%0d]: got v=%b a=%h i=%b l=%b exp v=1 a=00003000 i=%b l=0", k,
                         bus_req_valid, bus_req_addr, ifu_req_ready, lsu_req_ready, (k == 2));
            end
            tick();
        end
        ifu_req_valid = 1'b0;
        #1;
        compared++;
        if (lsu_req_ready !== 1'b1 || bus_req_addr !== 32'h4000) begin
            mismatched++;
            $display("FAIL hold_then_lsu: got l=%b a=%h exp l=1 a=00004000", lsu_req_ready, bus_req_addr);
        end
        tick();
        idle();
        test_drain(32'h300);
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++)
            push_exp(k[0], k[0] ? 32'h6000 + 32'(4 * (k / 2)) : 32'h5000 + 32'(4 * (k / 2)),
                     1'b0, 32'h0, 4'h0);
        push_exp(1'b0, 32'h5008, 1'b0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            ifu_req_valid = ~k[0]; ifu_req_addr = 32'h5000 + 32'(4 * (k / 2));
            lsu_req_valid = k[0];  lsu_req_addr = 32'h6000 + 32'(4 * (k / 2));
            tick();
        end
        idle();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h5008;
        for (int k = 0; k < 4; k++) begin
            bus_rsp_valid = (k == 2);
            bus_rsp_data  = 32'h77;
            #1;
            compared++;
            if (bus_req_valid !== (k == 3) || ifu_req_ready !== (k == 3) || lsu_req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL full[%0d]: got v=%b i=%b l=%b exp v=%b i=%b l=0", k, bus_req_valid,
                         ifu_req_ready, lsu_req_ready, (k == 3), (k == 3));
            end
            tick();
        end
        idle();
        test_drain(32'h80);
    endtask

    task automatic test_write();
        push_exp(1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 4'hF);
        push_exp(1'b0, 32'h200, 1'b0, 32'h0, 4'h0);
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h100;
        lsu_req_wen = 1'b1; lsu_req_wdata = 32'hDEADBEEF; lsu_req_wstrb = 4'hF;
        #1;
        compared++;
        if (bus_req_wen !== 1'b1 || bus_req_wdata !== 32'hDEADBEEF || bus_req_wstrb !== 4'hF) begin
            mismatched++;
            $display("FAIL write_payload: got w=%b d=%h s=%h exp 1 deadbeef f", bus_req_wen,
                     bus_req_wdata, bus_req_wstrb);
        end
        tick();
        lsu_req_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h200;
        #1;
        compared++;
        if (bus_req_wen !== 1'b0 || bus_req_wdata !== 32'h0 || bus_req_wstrb !== 4'h0) begin
            mismatched++;
            $display("FAIL ifu_payload: got w=%b d=%h s=%h exp 0 0 0", bus_req_wen, bus_req_wdata,
                     bus_req_wstrb);
        end
        tick();
        idle();
        test_drain(32'hC0);
    endtask

    task automatic test_orphan();
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h55;
        #1;
        compared++;
        if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL orphan_rsp: got i=%b l=%b exp 0 0", ifu_rsp_valid, lsu_rsp_valid);
        end
        tick();
        bus_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (arb_err_orphan !== 1'b1) begin
                mismatched++;
                $display("FAIL orphan_sticky[%0d]: got %b exp 1", k, arb_err_orphan);
            end
            tick();
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        compared++;
        if (arb_err_orphan !== 1'b0) begin
            mismatched++;
            $display("FAIL orphan_clear: got %b exp 0", arb_err_orphan);
        end
    endtask

    task automatic test_reset_mid();
        push_exp(1'b0, 32'h7000, 1'b0, 32'h0, 4'h0);
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h7000;
        #1;
        compared++;
        if (ifu_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_grant: got %b exp 1", ifu_req_ready);
        end
        tick();
        idle();
        rstn = 1'b0;
        own_q.delete();
        tick();
        rstn = 1'b1;
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h99;
        #1;
        compared++;
        if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_rsp: got i=%b l=%b exp 0 0", ifu_rsp_valid, lsu_rsp_valid);
        end
        tick();
        bus_rsp_valid = 1'b0;
        compared++;
        if (arb_err_orphan !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_orphan: got %b exp 1", arb_err_orphan);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ifu_only();
        test_starve();
        test_hold();
        test_full();
        test_write();
        test_orphan();
        test_reset_mid();
        tick();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_grants: got %0d exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
